// File: rtl/demux_2mapas_escrita.sv
// Write side of the 2-map selector: loads a map one column at a time into one of two banks.
// Optional: define MAPA_CLEAR_ON_START_EN to clear the selected bank on an accepted start.
module demux_2mapas_escrita #(
  parameter int N_COLS = 5,
  parameter int WIDTH  = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sel,
  input  logic [WIDTH-1:0] col_in,
  input  logic             col_valid,
  output logic             col_ready,
  output logic             busy,
  output logic             done,
  output logic [2:0]       col_idx,
  input  logic [2:0]       rd_col,
  output logic [WIDTH-1:0] mapa0,
  output logic [WIDTH-1:0] mapa1
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t           state_q;
  logic             sel_q;
  logic [2:0]       col_idx_q;
  logic             col_ready_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] bank0_q [N_COLS];
  logic [WIDTH-1:0] bank1_q [N_COLS];

  logic last_col;
  assign last_col = (col_idx_q == 3'(N_COLS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      sel_q       <= 1'b0;
      col_idx_q   <= '0;
      col_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      for (int unsigned j = 0; j < N_COLS; j++) begin
        bank0_q[j] <= '0;
        bank1_q[j] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            sel_q       <= sel;
            col_idx_q   <= '0;
            col_ready_q <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= LOAD;
`ifdef MAPA_CLEAR_ON_START_EN
            for (int unsigned j = 0; j < N_COLS; j++) begin
              if (sel) bank1_q[j] <= '0;
              else     bank0_q[j] <= '0;
            end
`endif
          end
        end
        LOAD: begin
          // col_ready is high throughout LOAD, so col_valid alone completes the handshake
          if (col_valid) begin
            if (sel_q) bank1_q[col_idx_q] <= col_in;
            else       bank0_q[col_idx_q] <= col_in;
            if (last_col) begin
              col_idx_q   <= '0;
              col_ready_q <= 1'b0;
              done_q      <= 1'b1;
              state_q     <= DONE;
            end else begin
              col_idx_q <= col_idx_q + 3'd1;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          col_ready_q <= 1'b0;
          busy_q      <= 1'b0;
          done_q      <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign col_ready = col_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign col_idx   = col_idx_q;

  always_comb begin
    mapa0 = '0;
    mapa1 = '0;
    if ({1'b0, rd_col} < 4'(N_COLS)) begin
      mapa0 = bank0_q[rd_col];
      mapa1 = bank1_q[rd_col];
    end
  end

endmodule

// File: tb/tb_demux_2mapas_escrita.sv
// Self-checking bench for demux_2mapas_escrita: map-level model plus directed literal checks.
module tb_demux_2mapas_escrita;

  localparam int NC = 5;
  localparam int W  = 7;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         sel;
  logic [W-1:0] col_in;
  logic         col_valid;
  logic         col_ready;
  logic         busy;
  logic         done;
  logic [2:0]   col_idx;
  logic [2:0]   rd_col;
  logic [W-1:0] mapa0;
  logic [W-1:0] mapa1;

  int n_cmp = 0;
  int n_err = 0;

  demux_2mapas_escrita #(.N_COLS(NC), .WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .sel(sel),
    .col_in(col_in), .col_valid(col_valid), .col_ready(col_ready),
    .busy(busy), .done(done), .col_idx(col_idx), .rd_col(rd_col),
    .mapa0(mapa0), .mapa1(mapa1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Map-level model: a load is "loading" until NC accepted columns, then one done cycle.
  logic [W-1:0] m0 [8];
  logic [W-1:0] m1 [8];
  bit           loading;
  bit           done_exp;
  bit           tgt;
  int unsigned  written;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin m0[i] = '0; m1[i] = '0; end
      loading = 0; done_exp = 0; tgt = 0; written = 0;
    end else if (done_exp) begin
      done_exp = 0;
    end else if (loading) begin
      if (col_valid) begin
        if (tgt) m1[written] = col_in; else m0[written] = col_in;
        written++;
        if (written == NC) begin
          loading = 0; done_exp = 1; written = 0;
        end
      end
    end else if (start) begin
      loading = 1; tgt = sel; written = 0;
`ifdef MAPA_CLEAR_ON_START_EN
      for (int i = 0; i < NC; i++) if (sel) m1[i] = '0; else m0[i] = '0;
`endif
    end
  end

  bit cmp_en = 0;
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("col_ready", 32'(col_ready), 32'(loading));
      chk("busy",      32'(busy),      32'(loading | done_exp));
      chk("done",      32'(done),      32'(done_exp));
      chk("col_idx",   32'(col_idx),   32'(written));
      chk("mapa0",     32'(mapa0),     32'(m0[rd_col]));
      chk("mapa1",     32'(mapa1),     32'(m1[rd_col]));
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic peek(input logic [2:0] rd, input logic [W-1:0] e0, input logic [W-1:0] e1);
    rd_col = rd;
    #2;
    chk($sformatf("lit_mapa0[%0d]", rd), 32'(mapa0), 32'(e0));
    chk($sformatf("lit_mapa1[%0d]", rd), 32'(mapa1), 32'(e1));
  endtask

  task automatic load_full(input logic s, input logic [W-1:0] c0, input logic [W-1:0] c1,
                           input logic [W-1:0] c2, input logic [W-1:0] c3, input logic [W-1:0] c4,
                           output int edges);
    logic [W-1:0] cols [5];
    int idx;
    cols[0] = c0; cols[1] = c1; cols[2] = c2; cols[3] = c3; cols[4] = c4;
    start = 1; sel = s;
    tick;
    start = 0; sel = 0;
    edges = 1; idx = 0;
    col_valid = 1; col_in = cols[0];
    while (!done && edges < 20) begin
      tick;
      edges++; idx++;
      if (idx < 5) col_in = cols[idx];
    end
    col_valid = 0; col_in = '0;
    if (!done) chk("load_timeout", 32'(edges), 32'(NC + 1));
    tick;
  endtask

  logic [W-1:0] v [5];
  logic [W-1:0] w [5];
  logic [W-1:0] x [5];
  int edges;
  logic [W-1:0] stale;

  initial begin
    v[0] = 7'b1000001; v[1] = 7'b1100011; v[2] = 7'b0011100; v[3] = 7'b1111111; v[4] = 7'b0000001;
    w[0] = 7'b0101010; w[1] = 7'b1010101; w[2] = 7'b0001111; w[3] = 7'b1110000; w[4] = 7'b0110110;
    x[0] = 7'b0000011; x[1] = 7'b0000110; x[2] = 7'b0001100; x[3] = 7'b0011000; x[4] = 7'b0110000;

    reset = 1; start = 0; sel = 0; col_in = '0; col_valid = 0; rd_col = '0;
    #1;
    cmp_en = 1;
    repeat (3) tick;
    reset = 0;
    tick;

    // Reset state
    for (int r = 0; r < 5; r++) peek(3'(r), '0, '0);
    chk("rst_col_ready", 32'(col_ready), 32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_done",      32'(done),      32'd0);

    // Full load into bank 0, col_valid held high
    load_full(1'b0, v[0], v[1], v[2], v[3], v[4], edges);
    chk("start_to_done_edges", 32'(edges), 32'd6);
    chk("done_one_cycle", 32'(done), 32'd0);
    for (int r = 0; r < 5; r++) peek(3'(r), v[r], '0);

    // Bank 1 with col_valid toggling
    start = 1; sel = 1;
    tick;
    start = 0; sel = 0;
    for (int k = 0; k < 10; k++) begin
      col_valid = (k % 2 == 0);
      col_in = col_valid ? w[k / 2] : 7'h55;
      tick;
      if (k == 8) chk("toggle_done", 32'(done), 32'd1);
    end
    col_valid = 0;
    chk("toggle_idle_busy", 32'(busy), 32'd0);
    for (int r = 0; r < 5; r++) peek(3'(r), v[r], w[r]);

    // start/sel mid-load must be ignored
    start = 1; sel = 0;
    tick;
    start = 0;
    for (int k = 0; k < 5; k++) begin
      col_valid = 1; col_in = x[k];
      if (k == 2) begin start = 1; sel = 1; end
      else begin start = 0; sel = 0; end
      tick;
    end
    col_valid = 0; start = 0; sel = 0;
    tick;
    for (int r = 0; r < 5; r++) peek(3'(r), x[r], w[r]);

    // Reset after 2 of 5 columns
    start = 1; sel = 1;
    tick;
    start = 0; sel = 0;
    col_valid = 1; col_in = 7'h7e; tick;
    col_in = 7'h3c; tick;
    col_valid = 0;
    rd_col = 3'd0;
    reset = 1;
    #1;
    chk("midrst_busy",   32'(busy),    32'd0);
    chk("midrst_idx",    32'(col_idx), 32'd0);
    chk("midrst_mapa0",  32'(mapa0),   32'd0);
    chk("midrst_mapa1",  32'(mapa1),   32'd0);
    tick;
    reset = 0;
    tick;
    load_full(1'b0, v[0], v[1], v[2], v[3], v[4], edges);
    chk("reload_edges", 32'(edges), 32'd6);
    for (int r = 0; r < 5; r++) peek(3'(r), v[r], '0);

    // Out-of-range read columns
    for (int r = 5; r < 8; r++) peek(3'(r), '0, '0);

    // Stale-column behaviour on a partial load
    load_full(1'b0, 7'h7f, 7'h7f, 7'h7f, 7'h7f, 7'h7f, edges);
    start = 1; sel = 0;
    tick;
    start = 0;
    col_valid = 1; col_in = 7'b0000001;
    tick;
    col_valid = 0;
`ifdef MAPA_CLEAR_ON_START_EN
    stale = 7'b0000000;
`else
    stale = 7'b1111111;
`endif
    peek(3'd0, 7'b0000001, '0);
    for (int r = 1; r < 5; r++) peek(3'(r), stale, '0);
    col_valid = 1; col_in = 7'h11;
    for (int k = 0; k < 4; k++) tick;
    col_valid = 0;
    tick;
    tick;

    cmp_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
